// File: rtl/risc_pkg.sv
// risc_pkg: shared datapath widths and op-type flag indices for the RISC pipeline.
package risc_pkg;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 8;
    localparam int NUM_OPS = 14;
    localparam int ADA = 0;
    localparam int ADZ = 1;
    localparam int ADC = 2;
    localparam int AWC = 3;
    localparam int ACA = 4;
    localparam int ACZ = 5;
    localparam int ACC = 6;
    localparam int ACW = 7;
    localparam int NDU = 8;
    localparam int NDC = 9;
    localparam int NDZ = 10;
    localparam int NCU = 11;
    localparam int NCC = 12;
    localparam int NCZ = 13;
endpackage

// File: rtl/dm_ram.sv
// dm_ram: single-port data RAM, synchronous write, registered read-before-write, no reset.
module dm_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem[addr_i] <= wdata_i;
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory.sv
// data_memory: MEM stage - data RAM access, write-back mux and flag/op-type pipeline to WB.
module data_memory
    import risc_pkg::*;
#(
    parameter int DATA_W = risc_pkg::DATA_W,
    parameter int ADDR_W = risc_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] y,
    input  logic [DATA_W-1:0] registerdata3,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic              adaRF, adzRF, adcRF, awcRF, acaRF, aczRF, accRF,
    input  logic              acwRF, nduRF, ndcRF, ndzRF, ncuRF, nccRF, nczRF,
    output logic              adaWB, adzWB, adcWB, awcWB, acaWB, aczWB, accWB,
    output logic              acwWB, nduWB, ndcWB, ndzWB, ncuWB, nccWB, nczWB,
    input  logic              carryRF,
    input  logic              zeroRF,
    output logic              carryWB,
    output logic              zeroWB,
    output logic              carryWB2,
    output logic              zeroWB2,
    output logic [DATA_W-1:0] DataMemoryout
);
    logic [NUM_OPS-1:0] flags_d, flags_q;
    logic [DATA_W-1:0]  y_q, ram_rdata;
    logic               rd_sel_q;
    logic [1:0]         carry_q, zero_q;

    assign flags_d = {nczRF, nccRF, ncuRF, ndzRF, ndcRF, nduRF, acwRF,
                      accRF, aczRF, acaRF, awcRF, adcRF, adzRF, adaRF};

    // Gating the write with reset_n keeps the RAM untouched while reset is held.
    dm_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk_i   (clock),
        .we_i    (mem_wr & reset_n),
        .addr_i  (y[ADDR_W-1:0]),
        .wdata_i (registerdata3),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel_q <= 1'b0;
            y_q      <= '0;
            flags_q  <= '0;
            carry_q  <= '0;
            zero_q   <= '0;
        end else begin
            rd_sel_q <= mem_rd;
            y_q      <= y;
            flags_q  <= flags_d;
            carry_q  <= {carry_q[0], carryRF};
            zero_q   <= {zero_q[0], zeroRF};
        end
    end

    // rd_sel_q resets to 0 and selects y_q (also 0), so the RAM needs no reset.
    assign DataMemoryout = rd_sel_q ? ram_rdata : y_q;
    assign carryWB  = carry_q[0];
    assign carryWB2 = carry_q[1];
    assign zeroWB   = zero_q[0];
    assign zeroWB2  = zero_q[1];

    assign adaWB = flags_q[ADA];
    assign adzWB = flags_q[ADZ];
    assign adcWB = flags_q[ADC];
    assign awcWB = flags_q[AWC];
    assign acaWB = flags_q[ACA];
    assign aczWB = flags_q[ACZ];
    assign accWB = flags_q[ACC];
    assign acwWB = flags_q[ACW];
    assign nduWB = flags_q[NDU];
    assign ndcWB = flags_q[NDC];
    assign ndzWB = flags_q[NDZ];
    assign ncuWB = flags_q[NCU];
    assign nccWB = flags_q[NCC];
    assign nczWB = flags_q[NCZ];
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized scoreboard bench for data_memory against a behavioural model.
module tb_data_memory;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] y = '0, registerdata3 = '0;
    logic        mem_rd = 1'b0, mem_wr = 1'b0;
    logic [13:0] fl_rf = '0;
    logic [13:0] fl_wb;
    logic        carryRF = 1'b0, zeroRF = 1'b0;
    logic        carryWB, zeroWB, carryWB2, zeroWB2;
    logic [15:0] DataMemoryout;

    typedef struct {
        logic [15:0] data;
        bit          known;
        logic [13:0] flags;
        logic        c1, z1, c2, z2;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] ref_mem [256];
    bit          ref_known [256];
    logic        ref_c1 = 1'b0, ref_z1 = 1'b0;
    int          passed = 0, total = 0;

    always #5 clock = ~clock;

    data_memory dut (
        .clock(clock), .reset_n(reset_n), .y(y), .registerdata3(registerdata3),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .adaRF(fl_rf[0]), .adzRF(fl_rf[1]), .adcRF(fl_rf[2]), .awcRF(fl_rf[3]),
        .acaRF(fl_rf[4]), .aczRF(fl_rf[5]), .accRF(fl_rf[6]), .acwRF(fl_rf[7]),
        .nduRF(fl_rf[8]), .ndcRF(fl_rf[9]), .ndzRF(fl_rf[10]), .ncuRF(fl_rf[11]),
        .nccRF(fl_rf[12]), .nczRF(fl_rf[13]),
        .adaWB(fl_wb[0]), .adzWB(fl_wb[1]), .adcWB(fl_wb[2]), .awcWB(fl_wb[3]),
        .acaWB(fl_wb[4]), .aczWB(fl_wb[5]), .accWB(fl_wb[6]), .acwWB(fl_wb[7]),
        .nduWB(fl_wb[8]), .ndcWB(fl_wb[9]), .ndzWB(fl_wb[10]), .ncuWB(fl_wb[11]),
        .nccWB(fl_wb[12]), .nczWB(fl_wb[13]),
        .carryRF(carryRF), .zeroRF(zeroRF), .carryWB(carryWB), .zeroWB(zeroWB),
        .carryWB2(carryWB2), .zeroWB2(zeroWB2), .DataMemoryout(DataMemoryout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Sets inputs for the coming rising edge and records what the outputs must show after it.
    task automatic apply(input logic [15:0] ya, input logic [15:0] d, input logic rd,
                         input logic wr, input logic [13:0] fl, input logic c, input logic z);
        exp_t e;
        int   a;
        y = ya; registerdata3 = d; mem_rd = rd; mem_wr = wr; fl_rf = fl; carryRF = c; zeroRF = z;
        a = int'(ya) % 256;
        e.known = !rd || ref_known[a];
        e.data  = rd ? ref_mem[a] : ya;
        e.flags = fl;
        e.c1 = c; e.z1 = z; e.c2 = ref_c1; e.z2 = ref_z1;
        ref_c1 = c; ref_z1 = z;
        if (wr) begin
            ref_mem[a] = d;
            ref_known[a] = 1'b1;
        end
        sb.push_back(e);
    endtask

    task automatic step(input logic [15:0] ya, input logic [15:0] d, input logic rd,
                        input logic wr, input logic [13:0] fl, input logic c, input logic z);
        @(negedge clock);
        apply(ya, d, rd, wr, fl, c, z);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " data"}, 32'(DataMemoryout), 32'h0);
        chk({tag, " flags"}, 32'(fl_wb), 32'h0);
        chk({tag, " carry/zero"}, {28'h0, carryWB, zeroWB, carryWB2, zeroWB2}, 32'h0);
    endtask

    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.known) chk("data", 32'(DataMemoryout), 32'(e.data));
            chk("wb flags", 32'(fl_wb), 32'(e.flags));
            chk("carryWB/zeroWB", {30'h0, carryWB, zeroWB}, {30'h0, e.c1, e.z1});
            chk("carryWB2/zeroWB2", {30'h0, carryWB2, zeroWB2}, {30'h0, e.c2, e.z2});
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_known[i] = 1'b0;
        y = 16'hFFFF; registerdata3 = 16'hFFFF; mem_rd = 1'b1; mem_wr = 1'b1;
        fl_rf = '1; carryRF = 1'b1; zeroRF = 1'b1;
        #2 chk_zero("reset async");
        repeat (3) begin
            @(posedge clock);
            #1 chk_zero("reset held");
        end
        @(negedge clock);
        reset_n = 1'b1;
        apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, '1, 1'b1, 1'b1);
        step(16'h0005, 16'hBEEF, 1'b0, 1'b1, '0, 1'b0, 1'b0);
        step(16'h0005, 16'h0000, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        step(16'h0105, 16'h1234, 1'b0, 1'b1, 14'h3000, 1'b0, 1'b1);
        step(16'h0005, 16'h0000, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        step(16'h0010, 16'hAAAA, 1'b0, 1'b1, '0, 1'b0, 1'b0);
        step(16'h0010, 16'h5555, 1'b1, 1'b1, '0, 1'b0, 1'b0);
        step(16'h0010, 16'h0000, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(16'h7F00, 16'h0000, 1'b0, 1'b0, 14'h0004, 1'b1, 1'b0);
        step(16'h0000, 16'h0000, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(16'h0005, 16'h0000, 1'b1, 1'b0, '0, 1'b1, 1'b1);
        step(16'h0105, 16'h0000, 1'b1, 1'b0, 14'h0100, 1'b1, 1'b1);
        // Pulse reset between edges with a load result on the output.
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1 chk_zero("mid reset");
        mem_rd = 1'b0; mem_wr = 1'b1; y = 16'h0005; registerdata3 = 16'hFFFF;
        @(posedge clock);
        #1 chk_zero("mid reset held");
        @(negedge clock);
        reset_n = 1'b1;
        ref_c1 = 1'b0; ref_z1 = 1'b0;
        apply(16'h0005, 16'h0000, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(16'h0010, 16'h0000, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ya;
            ya = {8'($urandom), 8'($urandom_range(0, 15))};
            step(ya, 16'($urandom), 1'($urandom), 1'($urandom), 14'($urandom),
                 1'($urandom), 1'($urandom));
        end
        step(16'h0000, 16'h0000, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clock);
        #3;
        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DATA_W, 16, datapath word width.
REQ-002 Parameter ADDR_W, 8, word-address bits used; memory depth is 2**ADDR_W words (256).
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 y  in  DATA_W  ALU result from the previous stage; used as the memory address and as the non-load write-back value.
REQ-006 registerdata3  in  DATA_W  store data.
REQ-007 mem_rd  in  1  load in this stage.
REQ-008 mem_wr  in  1  store in this stage.
REQ-009 adaRF, adzRF, adcRF, awcRF, acaRF, aczRF, accRF, acwRF, nduRF, ndcRF, ndzRF, ncuRF, nccRF, nczRF  in  1 each  one-hot arithmetic/logic op-type flags, RF stage.
REQ-010 adaWB … nczWB (same 14 names, WB suffix)  out  1 each  op-type flags, write-back stage.
REQ-011 carryRF, zeroRF  in  1  ALU carry and zero flags entering the stage.
REQ-012 carryWB, zeroWB  out  1  flags delayed by 1 cycle.
REQ-013 carryWB2, zeroWB2  out  1  flags delayed by 2 cycles.
REQ-014 DataMemoryout  out  DATA_W  registered write-back data.

Function
REQ-015 Address is y[ADDR_W-1:0]; upper bits of y are ignored, so addresses wrap modulo 2**ADDR_W.
REQ-016 On a rising edge with mem_wr=1, mem[addr] gets registerdata3.
REQ-017 On a rising edge with mem_rd=1, DataMemoryout gets mem[addr]; one-cycle load latency.
REQ-018 On a rising edge with mem_rd=0, DataMemoryout gets y (ALU result pass-through).
REQ-019 mem_rd=1 and mem_wr=1 in the same cycle with the same address: the read returns the old contents (read-before-write), and the write still completes.
REQ-020 Each xxWB output is the corresponding xxRF input registered once; there is no one-hot checking, so multiple set flags pass through unchanged.
REQ-021 carryWB and zeroWB are carryRF and zeroRF registered once; carryWB2 and zeroWB2 are carryWB and zeroWB registered once more.
REQ-022 The block has no handshake or stall; every register updates every cycle.

Reset
REQ-023 While reset_n=0, outputs hold asynchronously: DataMemoryout=0, all 14 xxWB=0, carryWB=carryWB2=zeroWB=zeroWB2=0.
REQ-024 Memory contents are not altered by reset; reads of never-written locations return an undefined value.
REQ-025 Writes are suppressed while reset_n=0; the first capture occurs on the first rising edge after reset_n rises.
REQ-026 Reset asserted mid-operation aborts any in-flight load result and clears both flag delay stages.

Structure
REQ-027 Shared package risc_pkg holds DATA_W, ADDR_W defaults and the 14 op-type flag index constants (ADA..NCZ), for use by ALU, decoder and register file.
REQ-028 One sub-module, dm_ram: 2**ADDR_W x DATA_W array with synchronous write and synchronous registered read (read-before-write), no reset.
REQ-029 Flag pipeline and write-back mux are in data_memory itself.

Verification
REQ-030 Reset: hold reset_n=0 with all inputs =1 -> every output 0; release -> next edge captures inputs.
REQ-031 Store/load: store y=0x0005, registerdata3=0xBEEF; next cycle load y=0x0005 -> DataMemoryout=0xBEEF one edge after the load.
REQ-032 Wrap: store at y=0x0105, data 0x1234; load y=0x0005 -> 0x1234.
REQ-033 Same-address read+write: mem[0x10]=0xAAAA; rd=wr=1, y=0x10, data 0x5555 -> DataMemoryout=0xAAAA; a later load returns 0x5555.
REQ-034 Pass-through and flags: mem_rd=0, y=0x7F00, adcRF=1, carryRF=1, zeroRF=0 -> after 1 edge DataMemoryout=0x7F00, adcWB=1, carryWB=1; after 2 edges carryWB2=1, zeroWB2=0.
REQ-035 Mid-run reset: pulse reset_n low between edges during a load -> DataMemoryout, carryWB2 and zeroWB2 become 0 immediately; memory data is retained.
